// File: rtl/inv_sbox_pkg.sv
// Shared types, constants and the inverse affine map for the iterative inverse S-box.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package inv_sbox_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] GF_RED    = 8'h1B;  // x^8 = x^4 + x^3 + x + 1
    localparam logic [7:0] INV_AFF_C = 8'h05;
    localparam logic [7:0] EXP_VAL   = 8'hFE;  // 254: x^254 == x^-1 in GF(2^8)
    localparam int         EXP_ITERS = 8;

    // Inverse of the AES affine transform: x_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ c_i
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        logic [7:0] x;
        for (int i = 0; i < 8; i++) begin
            x[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ INV_AFF_C[i];
        end
        return x;
    endfunction

endpackage

// File: rtl/inv_sbox_seq_gf_mul8.sv
// Combinational GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module gf_mul8
    import inv_sbox_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] acc;
    logic [7:0] sh;

    // Shift-and-add: accumulate a*x^i for each set bit of b, reducing as a is shifted.
    always_comb begin
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_RED : 8'h00);
        end
        p = acc;
    end

endmodule

// File: rtl/inv_sbox_seq.sv
// Iterative AES inverse S-box: inverse affine, then x^254 by square-and-multiply.
// Latency: accept at edge N, out_valid after edge N+8; one byte per 10 cycles at best.
// Backpressure: result held in DONE (in_ready low) until out_ready; INV_SBOX_SCAN_EN adds a 21-bit scan chain.
module inv_sbox_seq
    import inv_sbox_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       scan_en,
    input  logic       scand,
    output logic       scanq
);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] x_q, x_d;
    logic [7:0] r_q, r_d;

    logic [7:0] sq;
    logic [7:0] sqx;
    logic       scan_active;
    logic [20:0] chain_q;

    // Whole register file as one vector, x[0] nearest scand, state[1] at scanq.
    assign chain_q = {state_q, cnt_q, r_q, x_q};

`ifdef INV_SBOX_SCAN_EN
    logic [20:0] chain_nxt;
    assign scan_active = scan_en;
    assign chain_nxt   = {chain_q[19:0], scand};
    assign scanq       = chain_q[20];
`else
    logic unused_scan;
    assign scan_active = 1'b0;
    assign unused_scan = scan_en ^ scand ^ chain_q[20];
    assign scanq       = 1'b0;
`endif

    gf_mul8 u_sq  (.a(r_q), .b(r_q),  .p(sq));
    gf_mul8 u_mul (.a(sq),  .b(x_q),  .p(sqx));

    // Handshake flags come from state only; scan mode hides them.
    assign in_ready  = (state_q == IDLE) & ~scan_active;
    assign out_valid = (state_q == DONE) & ~scan_active;
    assign out       = r_q;

    // Next-state: FSM step, or a one-bit chain shift when scanning.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        r_d     = r_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = inv_affine(in);
                    r_d     = 8'h01;
                    cnt_d   = 3'(EXP_ITERS - 1);
                    state_d = EXP;
                end
            end
            EXP: begin
                r_d = EXP_VAL[cnt_q] ? sqx : sq;
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef INV_SBOX_SCAN_EN
        if (scan_en) begin
            state_d = state_t'(chain_nxt[20:19]);
            cnt_d   = chain_nxt[18:16];
            r_d     = chain_nxt[15:8];
            x_d     = chain_nxt[7:0];
        end
`endif
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            x_q     <= 8'h00;
            r_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            r_q     <= r_d;
        end
    end

endmodule
